// File: rtl/button_conditioner.sv
// button_conditioner: synchronizes and debounces a pushbutton, producing level, edge pulses,
// a one-shot long-press pulse, a press toggle and a wrapping press counter.
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int LONG_CYCLES     = 25000000,
    parameter int CNT_W           = 25
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_raw,
    output logic       btn_level,
    output logic       btn_rise,
    output logic       btn_fall,
    output logic       long_press,
    output logic       toggle,
    output logic [7:0] press_count
);
    typedef enum logic [1:0] {REL, CHK_P, PRS, CHK_R} state_t;
    // The check states are entered on the first differing sample, so DEBOUNCE_CYCLES
    // samples are complete when the counter holds DEBOUNCE_CYCLES-2.
    localparam logic [CNT_W-1:0] DB_END   = CNT_W'(DEBOUNCE_CYCLES - 2);
    localparam logic [CNT_W-1:0] LONG_END = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] LONG_SAT = CNT_W'(LONG_CYCLES);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             s1, btn_s, fired;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1    <= 1'b0;
            btn_s <= 1'b0;
        end else begin
            s1    <= btn_raw;
            btn_s <= s1;
        end
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= REL;
            cnt         <= '0;
            fired       <= 1'b0;
            btn_level   <= 1'b0;
            btn_rise    <= 1'b0;
            btn_fall    <= 1'b0;
            long_press  <= 1'b0;
            toggle      <= 1'b0;
            press_count <= '0;
        end else begin
            btn_rise   <= 1'b0;
            btn_fall   <= 1'b0;
            long_press <= 1'b0;
            case (state)
                REL: if (btn_s) begin
                    state <= CHK_P;
                    cnt   <= '0;
                end
                CHK_P: if (!btn_s) begin
                    state <= REL;
                end else if (cnt == DB_END) begin
                    state       <= PRS;
                    cnt         <= '0;
                    fired       <= 1'b0;
                    btn_level   <= 1'b1;
                    btn_rise    <= 1'b1;
                    toggle      <= ~toggle;
                    press_count <= press_count + 8'd1;
                end else begin
                    cnt <= cnt + ONE;
                end
                PRS: if (!btn_s) begin
                    state <= CHK_R;
                    cnt   <= '0;
                end else begin
                    if (cnt != LONG_SAT) cnt <= cnt + ONE;
                    // fired survives release bounces so one press yields one long_press
                    if (cnt == LONG_END && !fired) begin
                        long_press <= 1'b1;
                        fired      <= 1'b1;
                    end
                end
                CHK_R: if (btn_s) begin
                    state <= PRS;
                    cnt   <= '0;
                end else if (cnt == DB_END) begin
                    state     <= REL;
                    cnt       <= '0;
                    btn_level <= 1'b0;
                    btn_fall  <= 1'b1;
                end else begin
                    cnt <= cnt + ONE;
                end
                default: state <= REL;
            endcase
        end
    end
endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner: random and directed stimulus against a run-length debounce model.
module tb_button_conditioner;
    localparam int D = 4;
    localparam int L = 10;
    logic       clk = 1'b0, reset = 1'b0, btn_raw = 1'b0;
    logic       btn_level, btn_rise, btn_fall, long_press, toggle;
    logic [7:0] press_count;
    int total = 0, bad = 0;
    bit ms1, ms2, m_level, m_rise, m_fall, m_long, m_fired;
    int m_run, m_since, m_cnt;
    wire [12:0] dut_v = {btn_level, btn_rise, btn_fall, long_press, toggle, press_count};

    always #5 clk = ~clk;

    button_conditioner #(.DEBOUNCE_CYCLES(D), .LONG_CYCLES(L), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .btn_raw(btn_raw), .btn_level(btn_level),
        .btn_rise(btn_rise), .btn_fall(btn_fall), .long_press(long_press),
        .toggle(toggle), .press_count(press_count)
    );

    function automatic logic [12:0] exp_v();
        return {m_level, m_rise, m_fall, m_long, m_cnt[0], m_cnt[7:0]};
    endfunction

    task automatic model_reset();
        {ms1, ms2, m_level, m_rise, m_fall, m_long, m_fired} = '0;
        m_run = 0; m_since = -1; m_cnt = 0;
    endtask

    // Model: the level flips once D consecutive synchronized samples disagree with it;
    // a long press is the L-th consecutive high sample after entry or after a release bounce.
    task automatic step(input bit r);
        bit seen;
        btn_raw = r;
        @(posedge clk);
        seen = ms2; ms2 = ms1; ms1 = r;
        m_rise = 0; m_fall = 0; m_long = 0;
        if (m_level) begin
            m_since = !seen ? -1 : (m_since < 0 ? 0 : m_since + 1);
            if (m_since == L && !m_fired) begin m_long = 1; m_fired = 1; end
        end
        m_run = (seen != m_level) ? m_run + 1 : 0;
        if (m_run == D) begin
            m_level = seen; m_run = 0;
            if (seen) begin m_rise = 1; m_cnt++; m_since = 0; m_fired = 0; end
            else m_fall = 1;
        end
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0; btn_raw = 1'b0;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0; btn_raw = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        if (dut_v !== 13'd0) begin bad++; $display("FAIL reset_hold got %h want 0", dut_v); end
        total++;
        model_reset();
        @(negedge clk); reset = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step(1'b0);
            if (dut_v !== exp_v()) begin bad++; $display("FAIL reset_idle got %h want %h", dut_v, exp_v()); end
            total++;
        end
    endtask

    task automatic test_clean_press();
        int rise_at = -1, fall_at = -1;
        for (int i = 1; i <= 12; i++) begin
            step(1'b1);
            if (btn_rise && rise_at < 0) rise_at = i;
            if (dut_v !== exp_v()) begin bad++; $display("FAIL clean_press got %h want %h", dut_v, exp_v()); end
            total++;
        end
        if (rise_at != D + 2) begin bad++; $display("FAIL rise_latency got %0d want %0d", rise_at, D + 2); end
        total++;
        if ({btn_level, toggle, press_count} !== {1'b1, 1'b1, 8'd1}) begin
            bad++; $display("FAIL press_state got %b/%b/%0d want 1/1/1", btn_level, toggle, press_count);
        end
        total++;
        for (int i = 1; i <= 12; i++) begin
            step(1'b0);
            if (btn_fall && fall_at < 0) fall_at = i;
            if (dut_v !== exp_v()) begin bad++; $display("FAIL clean_release got %h want %h", dut_v, exp_v()); end
            total++;
        end
        if (fall_at != D + 2) begin bad++; $display("FAIL fall_latency got %0d want %0d", fall_at, D + 2); end
        total++;
    endtask

    task automatic test_bounce();
        int rises = 0;
        for (int i = 0; i < 14; i++) begin
            step(i < 3);
            rises += int'(btn_rise);
            if (dut_v !== exp_v()) begin bad++; $display("FAIL bounce got %h want %h", dut_v, exp_v()); end
            total++;
        end
        if (rises != 0 || press_count !== 8'd1) begin
            bad++; $display("FAIL bounce_count got rises=%0d cnt=%0d want 0/1", rises, press_count);
        end
        total++;
    endtask

    task automatic test_long_hold();
        int rise_at = -1, long_at = -1, longs = 0, fall_at = -1;
        for (int i = 1; i <= 30; i++) begin
            step(1'b1);
            if (btn_rise) rise_at = i;
            if (long_press) begin longs++; long_at = i; end
            if (dut_v !== exp_v()) begin bad++; $display("FAIL long_hold got %h want %h", dut_v, exp_v()); end
            total++;
        end
        if (longs != 1 || long_at - rise_at != L) begin
            bad++; $display("FAIL long_pulse got n=%0d dist=%0d want 1/%0d", longs, long_at - rise_at, L);
        end
        total++;
        for (int i = 1; i <= 10; i++) begin
            step(1'b0);
            if (btn_fall) fall_at = i;
            if (dut_v !== exp_v()) begin bad++; $display("FAIL long_release got %h want %h", dut_v, exp_v()); end
            total++;
        end
        if (fall_at != D + 2) begin bad++; $display("FAIL long_fall got %0d want %0d", fall_at, D + 2); end
        total++;
    endtask

    task automatic test_release_bounce();
        int falls = 0;
        for (int i = 0; i < 10; i++) step(1'b1);
        for (int i = 0; i < 14; i++) begin
            step(!(i < 2));
            falls += int'(btn_fall);
            if (dut_v !== exp_v()) begin bad++; $display("FAIL rel_bounce got %h want %h", dut_v, exp_v()); end
            total++;
        end
        if (falls != 0 || btn_level !== 1'b1) begin
            bad++; $display("FAIL rel_bounce_level got falls=%0d lvl=%b want 0/1", falls, btn_level);
        end
        total++;
        for (int i = 0; i < 10; i++) step(1'b0);
    endtask

    task automatic test_mid_reset();
        int rise_at = -1;
        for (int i = 0; i < 8; i++) step(1'b1);
        #2 reset = 1'b0;
        #1;
        if (dut_v !== 13'd0) begin bad++; $display("FAIL mid_reset got %h want 0", dut_v); end
        total++;
        model_reset();
        repeat (2) begin
            @(posedge clk); #1;
            if (btn_fall !== 1'b0) begin bad++; $display("FAIL mid_reset_fall got %b want 0", btn_fall); end
            total++;
        end
        @(negedge clk); reset = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            step(1'b1);
            if (btn_rise) rise_at = i;
            if (dut_v !== exp_v()) begin bad++; $display("FAIL post_reset got %h want %h", dut_v, exp_v()); end
            total++;
        end
        if (rise_at != D + 2) begin bad++; $display("FAIL post_reset_rise got %0d want %0d", rise_at, D + 2); end
        total++;
        for (int i = 0; i < 10; i++) step(1'b0);
    endtask

    task automatic test_wrap();
        int rises = 0;
        do_reset();
        for (int p = 0; p < 256; p++) begin
            for (int i = 0; i < 2 * (D + 3); i++) begin
                step(i < D + 3);
                rises += int'(btn_rise);
                if (dut_v !== exp_v()) begin bad++; $display("FAIL wrap p=%0d got %h want %h", p, dut_v, exp_v()); end
                total++;
            end
        end
        if (rises != 256 || press_count !== 8'd0 || toggle !== 1'b0) begin
            bad++; $display("FAIL wrap_end got rises=%0d cnt=%0d tog=%b want 256/0/0", rises, press_count, toggle);
        end
        total++;
    endtask

    task automatic test_random();
        bit lvl = 0;
        logic [2:0] prev = '0;
        int n = 0;
        while (n < 600) begin
            int len = $urandom_range(1, 16);
            lvl = ~lvl;
            for (int i = 0; i < len; i++) begin
                step(lvl);
                n++;
                if (dut_v !== exp_v()) begin bad++; $display("FAIL random n=%0d got %h want %h", n, dut_v, exp_v()); end
                total++;
                if ($countones({btn_rise, btn_fall, long_press}) > 1 || (prev & {btn_rise, btn_fall, long_press}) != 0) begin
                    bad++; $display("FAIL pulse_excl n=%0d got %b prev %b", n, {btn_rise, btn_fall, long_press}, prev);
                end
                total++;
                prev = {btn_rise, btn_fall, long_press};
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_clean_press();
        test_bounce();
        test_long_hold();
        test_release_bounce();
        test_mid_reset();
        test_wrap();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 The block SHALL take parameter DEBOUNCE_CYCLES, default 250000: stable cycles required to accept a button level change (>=2).
REQ-002 The block SHALL take parameter LONG_CYCLES, default 25000000: cycles of accepted press before long_press fires (> DEBOUNCE_CYCLES).
REQ-003 The block SHALL take parameter CNT_W, default 25: width of the shared stability/hold counter (must hold LONG_CYCLES).
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-006 btn_raw  input  1  raw asynchronous pushbutton; 1 = pressed.
REQ-007 btn_level  output  1  debounced button level.
REQ-008 btn_rise  output  1  one-cycle pulse on accepted press.
REQ-009 btn_fall  output  1  one-cycle pulse on accepted release.
REQ-010 long_press  output  1  one-cycle pulse when a press reaches LONG_CYCLES.
REQ-011 toggle  output  1  flips on every accepted press; drives the downstream blink stage's control input.
REQ-012 press_count  output  8  count of accepted presses, modulo 256.

Function
REQ-013 btn_raw SHALL pass through a 2-flop synchronizer; only the second flop output (btn_s) feeds logic.
REQ-014 FSM states SHALL be REL (released), CHK_P (checking press), PRS (pressed), CHK_R (checking release).
REQ-015 REL: btn_s=1 -> CHK_P, counter cleared to 0; otherwise stay.
REQ-016 CHK_P: btn_s=0 -> REL (bounce rejected, no output change); counter reaching DEBOUNCE_CYCLES-1 with btn_s=1 -> PRS.
REQ-017 On REL/CHK_P -> PRS transition: btn_level<=1, btn_rise pulses next cycle, toggle inverts, press_count increments, counter cleared.
REQ-018 PRS: counter increments each cycle, saturating at LONG_CYCLES; long_press SHALL pulse exactly once per press, the cycle counter reaches LONG_CYCLES-1.
REQ-019 PRS: btn_s=0 -> CHK_R, counter cleared.
REQ-020 CHK_R: btn_s=1 -> PRS (bounce rejected; hold counter restarts from 0, long_press remains suppressed if already fired this press); counter reaching DEBOUNCE_CYCLES-1 with btn_s=0 -> REL, btn_level<=0, btn_fall pulses.
REQ-021 Latency: raw edge to btn_rise/btn_fall SHALL be exactly DEBOUNCE_CYCLES+2 cycles for a clean edge.
REQ-022 btn_rise, btn_fall, long_press SHALL be registered, never high two consecutive cycles, never simultaneously high.
REQ-023 press_count SHALL wrap 255 -> 0 without any flag.
REQ-024 Glitches shorter than DEBOUNCE_CYCLES SHALL produce no output change.

Reset
REQ-025 While reset=0: FSM=REL, counter=0, synchronizer flops=0, btn_level=0, btn_rise=0, btn_fall=0, long_press=0, toggle=0, press_count=0.
REQ-026 Reset assertion mid-press SHALL immediately clear all outputs with no btn_fall pulse.
REQ-027 After reset release with btn_raw held 1, the block SHALL debounce normally and report one press (btn_rise after DEBOUNCE_CYCLES+2 cycles).

Verification (DEBOUNCE_CYCLES=4, LONG_CYCLES=10)
REQ-028 Clean press: btn_raw 0->1 held -> btn_rise single pulse at cycle 6, btn_level=1, toggle=1, press_count=1.
REQ-029 Bounce: btn_raw high 3 cycles then low -> all outputs unchanged, press_count=0.
REQ-030 Long hold: press held 20 cycles -> exactly one long_press, 10 cycles after btn_rise; release -> btn_fall 6 cycles after raw fall.
REQ-031 Wrap: 256 clean presses -> press_count=0, toggle=0.
REQ-032 Mid-press reset: reset=0 while btn_level=1 -> all outputs 0 asynchronously, no btn_fall; release reset with btn_raw=1 -> btn_rise 6 cycles later.
REQ-033 Release bounce: in PRS, btn_raw low 2 cycles then high -> btn_level stays 1, no btn_fall.
